mii_io_tx_ms: RTL and testbench

Multi-speed MII transmit-side I/O block for the PHY. It generates TX_CLK from the system clock at either 100 Mbit/s or 10 Mbit/s rate, chosen at runtime, and switches speed only on a period boundary so TX_CLK never glitches. It captures TX_EN/TX_ER/TXD once per TX_CLK period and presents the nibble on-chip with a one-cycle clock-enable strobe. It sits between the MII pads and the PCS transmit path and handles isolation and, optionally, jabber protection.

---
 rtl/mii_io_tx_ms.sv | 133 +++++++++++++
 tb/tb_mii_io_tx_ms.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mii_io_tx_ms.sv
// Multi-speed MII transmit-side I/O: TX_CLK generation, per-period capture of TX_EN/TX_ER/TXD
// with a clock-enable strobe, isolate gating. Optional jabber guard under MII_IO_TX_JABBER_EN.
module mii_io_tx_ms #(
  parameter int unsigned DIV_FAST     = 5,
  parameter int unsigned DIV_SLOW     = 50,
  parameter int unsigned JABBER_LIMIT = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       speed,
  input  logic       isolate,
  output logic       ce,
  output logic       enable,
  output logic       err,
  output logic [3:0] data,
  output logic       jabber,
  output logic       tx_clk,
  output logic       tx_clk_oe,
  input  logic       tx_en,
  input  logic       tx_er,
  input  logic [3:0] txd
);

  localparam int unsigned DIV_MAX = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
  localparam int unsigned PW      = $clog2(DIV_MAX);

  localparam logic [PW-1:0] LAST_FAST = PW'(DIV_FAST - 1);
  localparam logic [PW-1:0] LAST_SLOW = PW'(DIV_SLOW - 1);
  localparam logic [PW-1:0] HALF_FAST = PW'((DIV_FAST + 1) / 2);
  localparam logic [PW-1:0] HALF_SLOW = PW'((DIV_SLOW + 1) / 2);

  logic [PW-1:0] phase_q, phase_d;
  logic          speed_q, speed_d;
  logic          tx_clk_q, tx_clk_d;
  logic          ce_q, ce_d;
  logic          raw_en_q, raw_en_d;
  logic          raw_er_q, raw_er_d;
  logic [3:0]    data_q, data_d;
  logic [PW-1:0] last_c;
  logic [PW-1:0] half_d;
  logic          wrap_c;

  assign last_c = speed_q ? LAST_FAST : LAST_SLOW;
  assign wrap_c = (phase_q == last_c);

  // Period sequencing: speed and capture only change on the wrap edge.
  always_comb begin
    phase_d  = phase_q + PW'(1);
    speed_d  = speed_q;
    ce_d     = 1'b0;
    raw_en_d = raw_en_q;
    raw_er_d = raw_er_q;
    data_d   = data_q;
    if (wrap_c) begin
      phase_d  = '0;
      speed_d  = speed;
      ce_d     = 1'b1;
      raw_en_d = tx_en;
      raw_er_d = tx_er;
      data_d   = txd;
    end
    half_d   = speed_d ? HALF_FAST : HALF_SLOW;
    tx_clk_d = (phase_d < half_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= '0;
      speed_q  <= 1'b1;
      tx_clk_q <= 1'b1;
      ce_q     <= 1'b0;
      raw_en_q <= 1'b0;
      raw_er_q <= 1'b0;
      data_q   <= 4'h0;
    end else begin
      phase_q  <= phase_d;
      speed_q  <= speed_d;
      tx_clk_q <= tx_clk_d;
      ce_q     <= ce_d;
      raw_en_q <= raw_en_d;
      raw_er_q <= raw_er_d;
      data_q   <= data_d;
    end
  end

`ifdef MII_IO_TX_JABBER_EN
  localparam int unsigned   JW      = 16;
  localparam logic [JW-1:0] JAB_MAX = JW'(JABBER_LIMIT);

  logic [JW-1:0] jab_cnt_q, jab_cnt_d, jab_inc;
  logic          jabber_q, jabber_d;

  // Count consecutive captured TX_EN nibbles; any idle capture clears the guard.
  always_comb begin
    jab_inc   = (jab_cnt_q < JAB_MAX) ? (jab_cnt_q + JW'(1)) : jab_cnt_q;
    jab_cnt_d = jab_cnt_q;
    jabber_d  = jabber_q;
    if (wrap_c) begin
      if (tx_en) begin
        jab_cnt_d = jab_inc;
        jabber_d  = (jab_inc >= JAB_MAX);
      end else begin
        jab_cnt_d = '0;
        jabber_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jab_cnt_q <= '0;
      jabber_q  <= 1'b0;
    end else begin
      jab_cnt_q <= jab_cnt_d;
      jabber_q  <= jabber_d;
    end
  end

  assign jabber = jabber_q;
`else
  // Limit only matters when the jabber guard is built.
  localparam int unsigned unused_jabber_limit = JABBER_LIMIT;
  assign jabber = 1'b0;
`endif

  assign ce        = ce_q;
  assign data      = data_q;
  assign tx_clk    = tx_clk_q;
  assign tx_clk_oe = ~isolate;
  assign enable    = raw_en_q & ~isolate & ~jabber;
  assign err       = raw_er_q & enable;

endmodule

// File: tb/tb_mii_io_tx_ms.sv
// Directed bench for mii_io_tx_ms: table of per-cycle vectors at 100 Mbit/s plus
// hand sequences for isolate, speed switch, jabber and mid-period reset.
module tb_mii_io_tx_ms;

`ifdef MII_IO_TX_JABBER_EN
  localparam bit JAB_ON = 1'b1;
`else
  localparam bit JAB_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, speed, isolate, tx_en, tx_er;
  logic [3:0] txd;
  logic       ce, enable, err, jabber, tx_clk, tx_clk_oe;
  logic [3:0] data;

  int errors = 0;
  int checks = 0;

  mii_io_tx_ms #(.DIV_FAST(5), .DIV_SLOW(50), .JABBER_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .speed(speed), .isolate(isolate),
    .ce(ce), .enable(enable), .err(err), .data(data), .jabber(jabber),
    .tx_clk(tx_clk), .tx_clk_oe(tx_clk_oe),
    .tx_en(tx_en), .tx_er(tx_er), .txd(txd)
  );

  always #5 clk = ~clk;

  // {isolate, tx_en, tx_er, txd} applied, then {ce, tx_clk, tx_clk_oe, enable, err, data} expected
  typedef struct {
    logic       iso;
    logic       en;
    logic       er;
    logic [3:0] txd;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic iso, input logic en, input logic er, input logic [3:0] d,
                              input logic e_ce, input logic e_tx, input logic e_oe,
                              input logic e_en, input logic e_er, input logic [3:0] e_d);
    vec_t v;
    v.iso = iso; v.en = en; v.er = er; v.txd = d;
    v.exp = {e_ce, e_tx, e_oe, e_en, e_er, e_d};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ce(input int max_cycles, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (ce === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: ce not seen within %0d cycles", name, max_cycles);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(0,0,0,4'h0, 0,1,1,0,0,4'h0);
    vecs[1]  = mk(0,0,0,4'h0, 0,1,1,0,0,4'h0);
    vecs[2]  = mk(0,0,0,4'h0, 0,0,1,0,0,4'h0);
    vecs[3]  = mk(0,1,0,4'hA, 0,0,1,0,0,4'h0);
    vecs[4]  = mk(0,1,0,4'hA, 1,1,1,1,0,4'hA);
    vecs[5]  = mk(0,1,1,4'h5, 0,1,1,1,0,4'hA);
    vecs[6]  = mk(0,1,1,4'h5, 0,1,1,1,0,4'hA);
    vecs[7]  = mk(0,1,1,4'h5, 0,0,1,1,0,4'hA);
    vecs[8]  = mk(0,1,1,4'h5, 0,0,1,1,0,4'hA);
    vecs[9]  = mk(0,1,1,4'h5, 1,1,1,1,1,4'h5);
    vecs[10] = mk(1,1,0,4'h3, 0,1,0,0,0,4'h5);
    vecs[11] = mk(1,1,0,4'h3, 0,1,0,0,0,4'h5);
    vecs[12] = mk(1,1,0,4'h3, 0,0,0,0,0,4'h5);
    vecs[13] = mk(1,1,0,4'h3, 0,0,0,0,0,4'h5);
    vecs[14] = mk(1,1,0,4'h3, 1,1,0,0,0,4'h3);
    vecs[15] = mk(0,1,0,4'hF, 0,1,1,1,0,4'h3);
    vecs[16] = mk(0,1,0,4'hF, 0,1,1,1,0,4'h3);
    vecs[17] = mk(0,1,0,4'hF, 0,0,1,1,0,4'h3);
    vecs[18] = mk(0,1,0,4'hF, 0,0,1,1,0,4'h3);
    vecs[19] = mk(0,1,0,4'hF, 1,1,1,1,0,4'hF);

    rst_n = 1'b0; speed = 1'b1; isolate = 1'b0;
    tx_en = 1'b0; tx_er = 1'b0; txd = 4'h0;

    // Reset state
    @(negedge clk);
    chk("rst_outs", 32'({ce, tx_clk, tx_clk_oe, enable, err, data, jabber}), 32'(10'b0_1_1_0_0_0000_0));

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      isolate = vecs[i].iso; tx_en = vecs[i].en; tx_er = vecs[i].er; txd = vecs[i].txd;
      @(negedge clk);
      chk($sformatf("row%0d", i), 32'({ce, tx_clk, tx_clk_oe, enable, err, data}), 32'(vecs[i].exp));
    end

    // Isolate acts combinationally
    isolate = 1'b1;
    #1;
    chk("iso_on_comb", 32'({tx_clk_oe, enable, err}), 32'(3'b000));
    isolate = 1'b0;
    #1;
    chk("iso_off_comb", 32'({tx_clk_oe, enable, err}), 32'(3'b110));

    // Speed drop at phase 2: current fast period finishes, then 25 high / 25 low
    wait_ce(20, "sync_fast");
    @(negedge clk);
    @(negedge clk);
    speed = 1'b0;
    for (int k = 0; k < 53; k++) begin
      int p;
      @(negedge clk);
      p = (k < 2) ? -1 : (k - 2) % 50;
      chk($sformatf("sw_k%0d", k), 32'({tx_clk, ce}),
          32'({(k < 2) ? 1'b0 : ((p < 25) ? 1'b1 : 1'b0), (p == 0) ? 1'b1 : 1'b0}));
    end

    // Jabber: clear with an idle capture, then hold tx_en high
    tx_en = 1'b0;
    wait_ce(60, "jab_idle");
    chk("jab_idle", 32'({jabber, enable}), 32'(2'b00));
    tx_en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      logic ej;
      ej = JAB_ON && (k >= 8);
      wait_ce(60, $sformatf("jab_cap%0d", k));
      chk($sformatf("jab_cap%0d", k), 32'({jabber, enable}), 32'({ej, ~ej}));
    end
    tx_en = 1'b0;
    wait_ce(60, "jab_release");
    chk("jab_release", 32'({jabber, enable}), 32'(2'b00));

    // Mid-period reset at slow speed with enable high
    tx_en = 1'b1;
    wait_ce(60, "pre_rst");
    chk("pre_rst_en", 32'(enable), 32'(1'b1));
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 32'({ce, tx_clk, tx_clk_oe, enable, err, data, jabber}), 32'(10'b0_1_1_0_0_0000_0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_k%0d", k), 32'({tx_clk, ce}),
          32'({(k <= 2 || k == 5) ? 1'b1 : 1'b0, (k == 5) ? 1'b1 : 1'b0}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
